// File: rtl/kernel_conv_mac.sv
// kernel_conv_mac: 3x3 convolution multiply-accumulate stage.
//
// Takes one 3x3 weight window and the matching 3x3 pixel window per cycle. The
// nine products are registered, summed through an adder tree, and the window
// sums are accumulated over a group of N input channels. One signed result is
// emitted per group, with optional ReLU.
//
// Pipeline: stage 0 (channel counting) -> stage 1 (products) -> stage 2 (tree
// sum) -> stage 3 (accumulate/result). Fully pipelined, no back-pressure.
//
// Ports:
//   i_clock          clock, rising edge
//   i_reset          asynchronous active-low reset
//   i_valid          current cycle carries one channel's window
//   i_weight         nine signed weights, index 0..8 row-major
//   i_pixel          nine signed pixels, index 0..8 row-major
//   i_num_channels   channels per result; 0 means 2^INPUT_CHANNEL_WIDTH
//   i_relu_enable    clamp negative results to 0 (sampled at stage 3)
//   i_clear          synchronous flush of pipeline, counter and accumulator
//   o_result         signed convolution result, held between pulses
//   o_result_valid   one-cycle pulse marking a new o_result
//   o_channel_index  channels accepted so far in the current group
//   o_busy           work in flight or group partially accepted
module kernel_conv_mac #(
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned INPUT_CHANNEL_WIDTH = 8,
    parameter int unsigned KERNEL_TAPS         = 9,
    parameter int unsigned ACC_WIDTH           = 2 * DATA_WIDTH + 4 + INPUT_CHANNEL_WIDTH
) (
    input  logic                                      i_clock,
    input  logic                                      i_reset,
    input  logic                                      i_valid,
    input  logic [KERNEL_TAPS-1:0][DATA_WIDTH-1:0]    i_weight,
    input  logic [KERNEL_TAPS-1:0][DATA_WIDTH-1:0]    i_pixel,
    input  logic [INPUT_CHANNEL_WIDTH-1:0]            i_num_channels,
    input  logic                                      i_relu_enable,
    input  logic                                      i_clear,
    output logic [ACC_WIDTH-1:0]                      o_result,
    output logic                                      o_result_valid,
    output logic [INPUT_CHANNEL_WIDTH-1:0]            o_channel_index,
    output logic                                      o_busy
);

    localparam int unsigned ProdW = 2 * DATA_WIDTH;
    localparam int unsigned SumW  = 2 * DATA_WIDTH + 4;
    // One extra bit so a group length of 2^INPUT_CHANNEL_WIDTH is representable.
    localparam int unsigned LenW  = INPUT_CHANNEL_WIDTH + 1;

    // ------------------------------------------------------------------
    // Stage 0: channel counter and group length
    // ------------------------------------------------------------------
    logic [INPUT_CHANNEL_WIDTH-1:0] ch_idx_q, ch_idx_d;
    logic [LenW-1:0]                grp_len_q, grp_len_d, grp_len_cur;
    logic                           last_in;
    logic                           accept;

    assign accept = i_valid & ~i_clear;

    always_comb begin
        grp_len_cur = grp_len_q;
        // The group length is only sampled on the first window of a group.
        if (ch_idx_q == '0) begin
            if (i_num_channels == '0) begin
                grp_len_cur = {1'b1, {INPUT_CHANNEL_WIDTH{1'b0}}};
            end else begin
                grp_len_cur = {1'b0, i_num_channels};
            end
        end
        last_in = (({1'b0, ch_idx_q} + LenW'(1)) == grp_len_cur);

        ch_idx_d  = ch_idx_q;
        grp_len_d = grp_len_q;
        if (i_clear) begin
            ch_idx_d = '0;
        end else if (i_valid) begin
            grp_len_d = grp_len_cur;
            ch_idx_d  = last_in ? '0 : ch_idx_q + INPUT_CHANNEL_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: element-wise products
    // ------------------------------------------------------------------
    logic signed [ProdW-1:0] prod_d [KERNEL_TAPS];
    logic signed [ProdW-1:0] prod_q [KERNEL_TAPS];
    logic                    s1_valid_q, s1_last_q;

    always_comb begin
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            prod_d[k] = ProdW'($signed(i_weight[k])) * ProdW'($signed(i_pixel[k]));
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: adder tree over the nine products
    // ------------------------------------------------------------------
    logic signed [SumW-1:0] sum_d, sum_q;
    logic                   s2_valid_q, s2_last_q;

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            sum_d = sum_d + SumW'(prod_q[k]);
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: channel accumulation and result
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_sum;
    logic        [ACC_WIDTH-1:0] result_q, result_d;
    logic                        rvalid_q, rvalid_d;

    always_comb begin
        acc_sum  = acc_q + ACC_WIDTH'(sum_q);
        acc_d    = acc_q;
        result_d = result_q;
        rvalid_d = 1'b0;
        if (i_clear) begin
            acc_d = '0;
        end else if (s2_valid_q) begin
            if (s2_last_q) begin
                // Restart the accumulator on the same edge so groups can run back to back.
                acc_d    = '0;
                rvalid_d = 1'b1;
                if (i_relu_enable && acc_sum[ACC_WIDTH-1]) begin
                    result_d = '0;
                end else begin
                    result_d = acc_sum;
                end
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ch_idx_q   <= '0;
            grp_len_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                prod_q[k] <= '0;
            end
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            sum_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            ch_idx_q   <= ch_idx_d;
            grp_len_q  <= grp_len_d;
            s1_valid_q <= accept;
            s1_last_q  <= accept & last_in;
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                prod_q[k] <= prod_d[k];
            end
            s2_valid_q <= s1_valid_q & ~i_clear;
            s2_last_q  <= s1_last_q & ~i_clear;
            sum_q      <= sum_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign o_result        = result_q;
    assign o_result_valid  = rvalid_q;
    assign o_channel_index = ch_idx_q;
    assign o_busy          = (ch_idx_q != '0) | s1_valid_q | s2_valid_q;

endmodule
